// File: rtl/riscv_reg_pkg.sv
// Shared types and sizes for the integer register-file write-back path.
// Used by reg_wb_sched (optional forwarding build: REG_WB_BYPASS_EN).
package riscv_reg_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int PEND_W     = 2;

  localparam logic [REG_ADDR_W-1:0] REG_X0   = 5'd0;
  localparam logic [PEND_W-1:0]     PEND_MAX = '1;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req;

  // Simultaneous issue and commit cancel; commit never underflows.
  function automatic logic [PEND_W-1:0] pend_next(input logic [PEND_W-1:0] cnt,
                                                  input logic inc, input logic dec);
    logic [PEND_W-1:0] nxt;
    nxt = cnt;
    if (inc && !dec)
      nxt = cnt + 1'b1;
    else if (dec && !inc && cnt != '0)
      nxt = cnt - 1'b1;
    return nxt;
  endfunction

endpackage

// File: rtl/reg_wb_sched_if.sv
// Write-back request bundle from EX (req0) and MEM (req1) into reg_wb_sched.
// Requesters drive through master, the scheduler consumes through slave.
interface reg_wb_sched_if;
  import riscv_reg_pkg::*;

  logic                  req0_valid;
  logic [REG_ADDR_W-1:0] req0_rd;
  logic [XLEN-1:0]       req0_data;
  logic                  req0_ready;

  logic                  req1_valid;
  logic [REG_ADDR_W-1:0] req1_rd;
  logic [XLEN-1:0]       req1_data;
  logic                  req1_ready;

  modport master (
    output req0_valid, req0_rd, req0_data,
    output req1_valid, req1_rd, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_rd, req0_data,
    input  req1_valid, req1_rd, req1_data,
    output req0_ready, req1_ready
  );

endinterface

// File: rtl/reg_wb_rr_arb.sv
// Two-way round-robin arbiter for the single register-file write port.
// rr_q names the requester that wins a tie; it flips after every grant.
module reg_wb_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic rr_q, rr_d;

  always_comb begin
    grant = 2'b00;
    if (rst_n) begin
      if (valid[0] && (!valid[1] || !rr_q))
        grant[0] = 1'b1;
      else if (valid[1])
        grant[1] = 1'b1;
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (grant[0])
      rr_d = 1'b1;
    else if (grant[1])
      rr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_q <= 1'b0;
    else
      rr_q <= rr_d;
  end

endmodule

// File: rtl/reg_wb_sched.sv
// Register-file write-back scheduler: round-robin write-port sharing plus a
// pending-write scoreboard for RAW stalls. REG_WB_BYPASS_EN adds forwarding.
module reg_wb_sched
  import riscv_reg_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  reg_wb_sched_if.slave         wb,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic [XLEN-1:0]       wr_data
`ifdef REG_WB_BYPASS_EN
  ,
  output logic                  rs1_fwd,
  output logic                  rs2_fwd,
  output logic [XLEN-1:0]       rs1_fwd_data,
  output logic [XLEN-1:0]       rs2_fwd_data
`endif
);

  wb_req                         req [2];
  logic [1:0]                    grant;
  logic [REG_ADDR_W-1:0]         wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]               wr_data_q, wr_data_d;
  logic [REG_ADDR_W-1:0]         dec_rd;
  logic                          issue_fire;
  logic [NUM_REGS-1:0][PEND_W-1:0] cnt_q, cnt_d;

  always_comb begin
    req[0] = '{valid: wb.req0_valid, rd: wb.req0_rd, data: wb.req0_data};
    req[1] = '{valid: wb.req1_valid, rd: wb.req1_rd, data: wb.req1_data};
  end

  reg_wb_rr_arb u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .valid ({req[1].valid, req[0].valid}),
    .grant (grant)
  );

  assign wb.req0_ready = grant[0];
  assign wb.req1_ready = grant[1];

  // No grant loads x0/0 so the always-writing register file sees a no-op.
  always_comb begin
    wr_addr_d = REG_X0;
    wr_data_d = '0;
    if (grant[0]) begin
      wr_addr_d = req[0].rd;
      wr_data_d = req[0].data;
    end else if (grant[1]) begin
      wr_addr_d = req[1].rd;
      wr_data_d = req[1].data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q <= REG_X0;
      wr_data_q <= '0;
    end else begin
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

  // Commit point: with forwarding the grant cycle retires the write,
  // otherwise the cycle the write port actually carries it.
`ifdef REG_WB_BYPASS_EN
  assign dec_rd = wr_addr_d;
`else
  assign dec_rd = wr_addr_q;
`endif

  assign issue_ready = rst_n && ((issue_rd == REG_X0) ||
                                 (cnt_q[issue_rd] != PEND_MAX) ||
                                 (dec_rd == issue_rd));
  assign issue_fire  = issue_valid && issue_ready && (issue_rd != REG_X0);

  // dec_rd/issue_rd of x0 never hit, so cnt_q[0] holds its reset value.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_pend
    logic inc, dec;

    always_comb begin
      inc      = issue_fire && (issue_rd == REG_ADDR_W'(g));
      dec      = (dec_rd != REG_X0) && (dec_rd == REG_ADDR_W'(g));
      cnt_d[g] = pend_next(cnt_q[g], inc, dec);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        cnt_q[g] <= '0;
      else
        cnt_q[g] <= cnt_d[g];
    end
  end

  assign rs1_busy = (rs1_addr != REG_X0) && (cnt_q[rs1_addr] != '0);
  assign rs2_busy = (rs2_addr != REG_X0) && (cnt_q[rs2_addr] != '0);

`ifdef REG_WB_BYPASS_EN
  assign rs1_fwd      = (wr_addr_q != REG_X0) && (rs1_addr == wr_addr_q);
  assign rs2_fwd      = (wr_addr_q != REG_X0) && (rs2_addr == wr_addr_q);
  assign rs1_fwd_data = wr_data_q;
  assign rs2_fwd_data = wr_data_q;
`endif

endmodule

// File: tb/tb_reg_wb_sched.sv
// Directed bench for reg_wb_sched: expected write-port contents are queued
// when a request is driven and compared the cycle the DUT registers them.
module tb_reg_wb_sched;
  import riscv_reg_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid;
  logic [4:0]  issue_rd, rs1_addr, rs2_addr;
  logic        issue_ready, rs1_busy, rs2_busy;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
`ifdef REG_WB_BYPASS_EN
  logic        rs1_fwd, rs2_fwd;
  logic [31:0] rs1_fwd_data, rs2_fwd_data;
`endif

  always #5 clk = ~clk;

  reg_wb_sched_if wb_if();

  reg_wb_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_ready  (issue_ready),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_busy     (rs1_busy),
    .rs2_busy     (rs2_busy),
    .wb           (wb_if),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data)
`ifdef REG_WB_BYPASS_EN
    ,
    .rs1_fwd      (rs1_fwd),
    .rs2_fwd      (rs2_fwd),
    .rs1_fwd_data (rs1_fwd_data),
    .rs2_fwd_data (rs2_fwd_data)
`endif
  );

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  logic m_rr  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of write-back requests; check grants against the model.
  task automatic wb(input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                    input logic v1, input logic [4:0] rd1, input logic [31:0] d1,
                    input string tag);
    logic g0, g1;
    wb_if.req0_valid = v0; wb_if.req0_rd = rd0; wb_if.req0_data = d0;
    wb_if.req1_valid = v1; wb_if.req1_rd = rd1; wb_if.req1_data = d1;
    #1;
    g0 = v0 && (!v1 || !m_rr);
    g1 = v1 && !g0;
    chk({tag, ".rdy0"}, 32'(wb_if.req0_ready), 32'(g0));
    chk({tag, ".rdy1"}, 32'(wb_if.req1_ready), 32'(g1));
    if (g0)      q.push_back('{a: rd0, d: d0});
    else if (g1) q.push_back('{a: rd1, d: d1});
    else         q.push_back('{a: 5'd0, d: 32'd0});
    if (g0)      m_rr = 1'b1;
    else if (g1) m_rr = 1'b0;
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    wb_if.req0_valid = 1'b0;
    wb_if.req1_valid = 1'b0;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("wr_addr", 32'(wr_addr), 32'(e.a));
      chk("wr_data", wr_data, e.d);
    end
  endtask

  initial begin
    issue_valid = 1'b1; issue_rd = 5'd4; rs1_addr = 5'd1; rs2_addr = 5'd2;
    wb_if.req0_valid = 1'b1; wb_if.req0_rd = 5'd1; wb_if.req0_data = 32'h1;
    wb_if.req1_valid = 1'b1; wb_if.req1_rd = 5'd2; wb_if.req1_data = 32'h2;
    #2;
    chk("rst.rdy0", 32'(wb_if.req0_ready), 32'd0);
    chk("rst.rdy1", 32'(wb_if.req1_ready), 32'd0);
    chk("rst.issue_ready", 32'(issue_ready), 32'd0);
    chk("rst.wr_addr", 32'(wr_addr), 32'd0);
    chk("rst.busy", 32'({rs1_busy, rs2_busy}), 32'd0);
    issue_valid = 1'b0; wb_if.req0_valid = 1'b0; wb_if.req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      step();
      chk("idle.wr_addr", 32'(wr_addr), 32'd0);
      chk("idle.wr_data", wr_data, 32'd0);
      chk("idle.rdy", 32'({wb_if.req0_ready, wb_if.req1_ready}), 32'd0);
      chk("idle.busy", 32'({rs1_busy, rs2_busy}), 32'd0);
    end
    for (int r = 0; r < 32; r++) begin
      issue_rd = 5'(r);
      #1;
      chk("idle.issue_ready", 32'(issue_ready), 32'd1);
    end

    // Issue rd5, then EX writes it back.
    step();
    issue_valid = 1'b1; issue_rd = 5'd5;
    #1 chk("iss5.ready", 32'(issue_ready), 32'd1);
    step();
    issue_valid = 1'b0; rs1_addr = 5'd5;
    #1 chk("iss5.busy_n1", 32'(rs1_busy), 32'd1);
    wb(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, "wb5");
    chk("wb5.busy_grant", 32'(rs1_busy), 32'd1);
    step();
`ifdef REG_WB_BYPASS_EN
    chk("wb5.busy_g1", 32'(rs1_busy), 32'd0);
    chk("wb5.fwd", 32'(rs1_fwd), 32'd1);
    chk("wb5.fwd_data", rs1_fwd_data, 32'hDEADBEEF);
`else
    chk("wb5.busy_g1", 32'(rs1_busy), 32'd1);
`endif
    step();
    chk("wb5.busy_g2", 32'(rs1_busy), 32'd0);
    chk("wb5.idle_addr", 32'(wr_addr), 32'd0);

    // Round-robin from a fresh reset, both requesters valid.
    rst_n = 1'b0; #1; rst_n = 1'b1; m_rr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wb(1'b1, 5'd1, 32'hA0 + 32'(i), 1'b1, 5'd2, 32'hB0 + 32'(i), "rr");
      step();
    end
    rs1_addr = 5'd1;
    #1 chk("rr.no_underflow", 32'(rs1_busy), 32'd0);

    // Saturate rd7 and wait for a write-back to free a slot.
    rs2_addr = 5'd7;
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1; issue_rd = 5'd7;
      #1 chk("iss7.ready", 32'(issue_ready), 32'd1);
      step();
    end
    #1 chk("iss7.full", 32'(issue_ready), 32'd0);
    chk("iss7.busy", 32'(rs2_busy), 32'd1);
    step();
    chk("iss7.full_hold", 32'(issue_ready), 32'd0);
    wb(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, "wb7");
`ifdef REG_WB_BYPASS_EN
    chk("iss7.ready_grant", 32'(issue_ready), 32'd1);
    step();
`else
    chk("iss7.ready_grant", 32'(issue_ready), 32'd0);
    step();
    chk("iss7.ready_g1", 32'(issue_ready), 32'd1);
    step();
`endif
    issue_valid = 1'b0;
    #1 chk("iss7.full_again", 32'(issue_ready), 32'd0);

    // Same-cycle issue and commit on rd9 with one write outstanding.
    step();
    issue_valid = 1'b1; issue_rd = 5'd9;
    step();
    issue_valid = 1'b0; rs1_addr = 5'd9;
    #1 chk("iss9.busy", 32'(rs1_busy), 32'd1);
`ifdef REG_WB_BYPASS_EN
    issue_valid = 1'b1;
    wb(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, "wb9");
    chk("iss9.ready", 32'(issue_ready), 32'd1);
    step();
    issue_valid = 1'b0;
`else
    wb(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, "wb9");
    step();
    issue_valid = 1'b1;
    #1 chk("iss9.ready", 32'(issue_ready), 32'd1);
    step();
    issue_valid = 1'b0;
`endif
    step();
    step();
    chk("iss9.busy_kept", 32'(rs1_busy), 32'd1);

    // Reset in the middle of traffic.
    rs1_addr = 5'd3; rs2_addr = 5'd7;
    issue_valid = 1'b1; issue_rd = 5'd3;
    wb(1'b1, 5'd12, 32'hCC, 1'b0, 5'd0, 32'd0, "wb12");
    step();
    issue_valid = 1'b0;
    #1 chk("mid.busy3", 32'(rs1_busy), 32'd1);
    wb_if.req0_valid = 1'b1; wb_if.req0_rd = 5'd12; wb_if.req0_data = 32'hEE;
    rst_n = 1'b0;
    #1;
    chk("mid.wr_addr", 32'(wr_addr), 32'd0);
    chk("mid.wr_data", wr_data, 32'd0);
    chk("mid.busy", 32'({rs1_busy, rs2_busy}), 32'd0);
    chk("mid.rdy0", 32'(wb_if.req0_ready), 32'd0);
    chk("mid.issue_ready", 32'(issue_ready), 32'd0);
    wb_if.req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; m_rr = 1'b0;
    step();
    chk("post.wr_addr", 32'(wr_addr), 32'd0);
    chk("post.wr_data", wr_data, 32'd0);
    rs1_addr = 5'd9;
    #1 chk("post.busy9", 32'({rs1_busy, rs2_busy}), 32'd0);
    chk("sb.drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
